// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one sequential 8x8 multiplier between
// NREQ requesters, with a watchdog that aborts a transaction the multiplier never finishes.
//
// state | meaning
// IDLE  | no transaction; arbitrate among req
// LOAD  | pulse mult_ld with the latched operands
// WAIT  | wait for mult_rdy or watchdog expiry
// DONE  | pulse done (and err on timeout) to the winner
module mult_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] op_a,
    input  logic [8*NREQ-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [15:0]       res,
    output logic              busy,
    output logic              mult_ld,
    output logic [7:0]        mult_a,
    output logic [7:0]        mult_b,
    input  logic              mult_rdy,
    input  logic [15:0]       mult_res
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [7:0]      wd_q, wd_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [15:0]     res_q, res_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    logic            err_q, err_d;
    logic [IW-1:0]   pick;

    // First requester at or above the round-robin pointer, wrapping.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            wd_q    <= '0;
            gnt_q   <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            wd_q    <= wd_d;
            gnt_q   <= gnt_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        wd_d    = wd_q;
        gnt_d   = gnt_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    win_d   = pick;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    a_d     = op_a[{pick, 3'b000} +: 8];
                    b_d     = op_b[{pick, 3'b000} +: 8];
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // mult_rdy may still be high from the previous product; not sampled here.
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + 8'd1;
                if (mult_rdy) begin
                    res_d   = mult_res;
                    state_d = S_DONE;
                end else if (wd_q == 8'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                err_d   = 1'b0;
                ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are qualified by reset so an abort in progress emits nothing.
    always_comb begin
        mult_ld = reset && (state_q == S_LOAD);
        busy    = (state_q != S_IDLE);
        done    = (reset && state_q == S_DONE) ? gnt_q : '0;
        err     = (reset && state_q == S_DONE && err_q) ? gnt_q : '0;
    end

    assign gnt    = gnt_q;
    assign res    = res_q;
    assign mult_a = a_q;
    assign mult_b = b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized and directed bench for mult_share_arbiter; a transaction-level
// model predicts grant order, strobe timing, results and timeouts.
module tb_mult_share_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] op_a, op_b;
    logic [NREQ-1:0]   gnt, done, err;
    logic [15:0]       res;
    logic              busy, mult_ld;
    logic [7:0]        mult_a, mult_b;
    logic              mult_rdy;
    logic [15:0]       mult_res;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .done(done), .err(err), .res(res), .busy(busy),
        .mult_ld(mult_ld), .mult_a(mult_a), .mult_b(mult_b),
        .mult_rdy(mult_rdy), .mult_res(mult_res)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Transaction-level model state
    bit              m_act;
    int              m_win, m_ptr, m_g, m_d, m_L;
    logic [7:0]      m_a, m_b;
    logic [15:0]     m_res;
    bit              m_err;
    logic [15:0]     exp_res;
    logic [7:0]      exp_a, exp_b;
    logic [NREQ-1:0] last_done;
    int              n_done;
    int              lat_force;
    bit              stale_force;
    logic [NREQ-1:0] prev_gnt;
    logic [NREQ-1:0] gnt_hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] one;
        logic [NREQ-1:0] exp_gnt;
        one = 1;
        // Multiplier model
        if (m_act && cyc == m_g) begin
            mult_rdy = stale_force ? 1'b1 : 1'($urandom_range(0, 1));
            mult_res = 16'($urandom);
        end else if (m_act && cyc == m_g + m_L) begin
            mult_rdy = 1'b1;
            mult_res = 16'(m_a) * 16'(m_b);
        end else if (m_act && cyc > m_g && cyc < m_d) begin
            mult_rdy = 1'b0;
            mult_res = 16'($urandom);
        end else begin
            mult_rdy = 1'($urandom_range(0, 1));
            mult_res = 16'($urandom);
        end

        @(negedge clk);
        if (gnt != 0 && prev_gnt == 0) gnt_hist.push_back(gnt);
        prev_gnt = gnt;
        if (!reset) begin
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_ld", mult_ld, 0);
        end else begin
            exp_gnt = m_act ? (one << m_win) : '0;
            if (m_act && cyc == m_d) exp_res = m_res;
            chk("gnt", gnt, exp_gnt);
            chk("busy", busy, m_act);
            chk("mult_ld", mult_ld, m_act && cyc == m_g);
            chk("done", done, (m_act && cyc == m_d) ? exp_gnt : '0);
            chk("err", err, (m_act && cyc == m_d && m_err) ? exp_gnt : '0);
            chk("res", res, exp_res);
            chk("mult_a", mult_a, exp_a);
            chk("mult_b", mult_b, exp_b);
        end

        last_done = '0;
        if (!reset) begin
            m_act = 0; m_ptr = 0; exp_res = 0; exp_a = 0; exp_b = 0;
        end else if (m_act) begin
            if (cyc == m_d) begin
                m_act = 0;
                m_ptr = (m_win + 1) % NREQ;
                n_done++;
                last_done = one << m_win;
            end
        end else if (req != 0) begin
            for (int k = NREQ - 1; k >= 0; k--)
                if (req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
            m_act = 1;
            m_g   = cyc + 1;
            m_a   = op_a[8*m_win +: 8];
            m_b   = op_b[8*m_win +: 8];
            exp_a = m_a;
            exp_b = m_b;
            if (lat_force != 0) m_L = lat_force;
            else begin
                case ($urandom_range(0, 15))
                    0:       m_L = TIMEOUT;
                    1:       m_L = TIMEOUT + 3;
                    default: m_L = $urandom_range(1, 10);
                endcase
            end
            if (m_L <= TIMEOUT) begin
                m_d = m_g + m_L + 1; m_res = 16'(m_a) * 16'(m_b); m_err = 0;
            end else begin
                m_d = m_g + TIMEOUT + 1; m_res = 0; m_err = 1;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_done(input int n);
        int target;
        target = n_done + n;
        for (int i = 0; i < 400 && n_done < target; i++) step();
        chk("done_budget", 32'(n_done >= target), 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; req = '0; op_a = '0; op_b = '0;
        mult_rdy = 1'b0; mult_res = '0;
        m_act = 0; m_ptr = 0; m_win = 0; m_g = 0; m_d = 0; m_L = 1;
        m_a = 0; m_b = 0; m_res = 0; m_err = 0;
        exp_res = 0; exp_a = 0; exp_b = 0; last_done = 0; n_done = 0;
        lat_force = 0; stale_force = 0; prev_gnt = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) step();

        // Single request 0xFF * 0xFF
        op_a[7:0] = 8'hFF; op_b[7:0] = 8'hFF; lat_force = 8;
        req = 4'b0001;
        run_until_done(1);
        req = '0;
        chk("single_res", res, 16'hFE01);
        step(); step();

        // Round robin from a fresh pointer
        pulse_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[8*i +: 8] = 8'(i + 1);
            op_b[8*i +: 8] = 8'h10;
        end
        lat_force = 0;
        gnt_hist.delete();
        req = 4'b1111;
        run_until_done(5);
        chk("rr_len", gnt_hist.size(), 5);
        if (gnt_hist.size() == 5) begin
            chk("rr_g0", gnt_hist[0], 4'b0001);
            chk("rr_g1", gnt_hist[1], 4'b0010);
            chk("rr_g2", gnt_hist[2], 4'b0100);
            chk("rr_g3", gnt_hist[3], 4'b1000);
            chk("rr_g4", gnt_hist[4], 4'b0001);
        end

        // Pointer wrap: finish on requester 3, then 1001
        run_until_done(3);
        req = 4'b1001;
        gnt_hist.delete();
        run_until_done(2);
        chk("wrap_len", gnt_hist.size(), 2);
        if (gnt_hist.size() == 2) begin
            chk("wrap_g0", gnt_hist[0], 4'b0001);
            chk("wrap_g1", gnt_hist[1], 4'b1000);
        end

        // Timeout with a pending request behind it
        req = 4'b0100; lat_force = 200;
        step();
        req = 4'b0101;
        run_until_done(1);
        chk("to_res", res, 16'h0000);
        req = 4'b0001; lat_force = 5;
        run_until_done(1);
        req = '0;
        chk("after_to_res", res, 16'h0010);
        step();

        // Stale rdy during LOAD plus rdy exactly on the timeout cycle
        stale_force = 1; lat_force = TIMEOUT;
        req = 4'b0010;
        step();
        req = '0;
        run_until_done(1);
        chk("tie_res", res, 16'h0020);
        stale_force = 0;
        step();

        // Reset in the middle of WAIT
        req = 4'b1000; lat_force = 200;
        for (int i = 0; i < 5; i++) step();
        pulse_reset();
        req = '0;
        for (int i = 0; i < 4; i++) step();
        lat_force = 3;
        req = 4'b0110;
        gnt_hist.delete();
        run_until_done(1);
        req = '0;
        chk("post_rst_gnt", gnt_hist.size() > 0 ? gnt_hist[0] : 4'b0000, 4'b0010);
        step();

        // Randomized traffic
        lat_force = 0;
        for (int n = 0; n < 3000; n++) begin
            op_a = 32'($urandom);
            op_b = 32'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (last_done[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
                else if (m_act && m_win == i && cyc > m_g && $urandom_range(0, 31) == 0) req[i] = 1'b0;
            end
            reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            step();
        end
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
